// File: rtl/and4_rr_arbiter.sv
// and4_rr_arbiter: round-robin arbiter that shares one registered W-bit AND
// datapath (y = a & b) between NREQ requesters. The result is returned with
// the id of the requester that owns it.
// Optional feature: define AND4_ARB_CNT_EN to add a saturating 8-bit grant
// counter per requester on output grant_cnt.
module and4_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        a_in,
  input  logic [NREQ*W-1:0]        b_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [W-1:0]             rsp_y,
  input  logic                     rsp_ready
`ifdef AND4_ARB_CNT_EN
  ,
  output logic [NREQ*8-1:0]        grant_cnt
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [IDW-1:0]  r_rr_ptr;
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [W-1:0]    r_rsp_y;

  logic            w_found;
  logic [IDW-1:0]  w_win_id;
  logic [NREQ-1:0] w_gnt_raw;
  logic [W-1:0]    w_win_y;
  logic            w_fire;
  int unsigned     w_idx;

  // Round-robin search starting just after the last winner; first set req wins.
  always_comb begin
    w_found   = 1'b0;
    w_win_id  = '0;
    w_idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_win_id = IDW'(w_idx);
      end
    end
    w_gnt_raw = '0;
    if (w_found) begin
      w_gnt_raw[w_win_id] = 1'b1;
    end
  end

  // Winner's operands through the shared AND datapath.
  always_comb begin
    w_win_y = a_in[int'(w_win_id)*W +: W] & b_in[int'(w_win_id)*W +: W];
  end

  // Next-state and grant decode; gnt is forced low during reset and in StResp.
  always_comb begin
    w_state_d = r_state;
    gnt       = '0;
    w_fire    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_found && !rst) begin
          gnt       = w_gnt_raw;
          w_fire    = 1'b1;
          w_state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Capture winner's result and advance the pointer; clear valid on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= IDW'(NREQ - 1);
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_y     <= '0;
    end else begin
      if (w_fire) begin
        r_rsp_y     <= w_win_y;
        r_rsp_id    <= w_win_id;
        r_rr_ptr    <= w_win_id;
        r_rsp_valid <= 1'b1;
      end else if (r_state == StResp && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_y     = r_rsp_y;

`ifdef AND4_ARB_CNT_EN
  logic [NREQ*8-1:0] r_grant_cnt;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
    // Saturating per-requester grant counter.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_grant_cnt[gi*8 +: 8] <= 8'h00;
      end else if (gnt[gi] && r_grant_cnt[gi*8 +: 8] != 8'hFF) begin
        r_grant_cnt[gi*8 +: 8] <= r_grant_cnt[gi*8 +: 8] + 8'h01;
      end
    end
  end

  assign grant_cnt = r_grant_cnt;
`else
  // Counters absent; arbitration is unaffected.
`endif

endmodule
